raster_timing_gen: RTL



---
 rtl/raster_pkg.sv | 35 +++
 rtl/raster_line_cmp.sv | 39 +++
 rtl/raster_timing_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared types, default raster geometry and helpers for raster_timing_gen.
package raster_pkg;

  typedef logic [8:0] hcnt_t;
  typedef logic [8:0] vcnt_t;

  localparam hcnt_t DEF_H_TOTAL     = 9'd384;
  localparam hcnt_t DEF_H_ACT_START = 9'd128;
  localparam hcnt_t DEF_HB_START    = 9'd28;
  localparam hcnt_t DEF_HS_START    = 9'd44;
  localparam hcnt_t DEF_HS_END      = 9'd76;
  localparam hcnt_t DEF_HB_END      = 9'd108;
  localparam hcnt_t DEF_INT_LEN     = 9'd128;

  localparam vcnt_t DEF_V_TOTAL     = 9'd312;
  localparam vcnt_t DEF_V_ACT       = 9'd192;
  localparam vcnt_t DEF_VB_START    = 9'd236;
  localparam vcnt_t DEF_VS_START    = 9'd240;
  localparam vcnt_t DEF_VS_END      = 9'd244;
  localparam vcnt_t DEF_VB_END      = 9'd260;

  localparam int DEF_NUM_LINE_INT = 2;
  localparam int DEF_FLASH_BITS   = 5;

  // Pixel phase within each 8-pixel slot that the CPU may use without waiting.
  localparam logic [2:0] CPU_SLOT = 3'd5;

  // A line-interrupt register holding this value never matches a visible line.
  localparam logic [7:0] LINE_OFF = 8'd255;

  function automatic logic is_cpu_slot(input logic [2:0] phase);
    return phase == CPU_SLOT;
  endfunction

endpackage

// File: rtl/raster_line_cmp.sv
// One programmable line-interrupt channel: line number register plus comparator.
module raster_line_cmp
  import raster_pkg::*;
#(
  parameter vcnt_t V_ACT   = DEF_V_ACT,
  parameter hcnt_t INT_LEN = DEF_INT_LEN
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ce_6mn,
  input  logic [8:0] hc,
  input  logic [8:0] vc,
  output logic       int_line
);

  logic [7:0] line_no;
  logic       hit;

  // Compare uses the register's current value, so a write landing on the same
  // clock as a compare only takes effect from the following ce_6mn.
  assign hit = ({1'b0, line_no} < V_ACT) &&
               (vc == {1'b0, line_no}) &&
               (hc < INT_LEN);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      line_no  <= LINE_OFF;
      int_line <= 1'b0;
    end else begin
      if (wr_en)  line_no  <= din;
      if (ce_6mn) int_line <= hit;
    end
  end

endmodule

// File: rtl/raster_timing_gen.sv
// Configurable raster counters, blank/sync, fetch qualifier and interrupts.
// Optional light-pen latches are built when RASTER_LIGHTPEN_EN is defined.
module raster_timing_gen
  import raster_pkg::*;
#(
  parameter hcnt_t H_TOTAL      = DEF_H_TOTAL,
  parameter vcnt_t V_TOTAL      = DEF_V_TOTAL,
  parameter hcnt_t H_ACT_START  = DEF_H_ACT_START,
  parameter vcnt_t V_ACT        = DEF_V_ACT,
  parameter hcnt_t HB_START     = DEF_HB_START,
  parameter hcnt_t HS_START     = DEF_HS_START,
  parameter hcnt_t HS_END       = DEF_HS_END,
  parameter hcnt_t HB_END       = DEF_HB_END,
  parameter vcnt_t VB_START     = DEF_VB_START,
  parameter vcnt_t VS_START     = DEF_VS_START,
  parameter vcnt_t VS_END       = DEF_VS_END,
  parameter vcnt_t VB_END       = DEF_VB_END,
  parameter int    NUM_LINE_INT = DEF_NUM_LINE_INT,
  parameter hcnt_t INT_LEN      = DEF_INT_LEN,
  parameter int    FLASH_BITS   = DEF_FLASH_BITS
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_6mp,
  input  logic                    ce_6mn,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_sel,
  input  logic [7:0]              cfg_din,
  input  logic                    wide,
  input  logic                    soff,
  input  logic [1:0]              mode,
  input  logic                    full_zx,
  output logic [8:0]              hc,
  output logic [8:0]              vc,
  output logic                    HBlank,
  output logic                    HSync,
  output logic                    VBlank,
  output logic                    VSync,
  output logic                    fetch,
  output logic                    fetch_stb,
  output logic [NUM_LINE_INT-1:0] INT_line,
  output logic                    INT_frame,
  output logic                    flash,
  output logic                    io_contention,
  output logic                    mem_contention,
  output logic [7:0]              lpen,
  output logic [7:0]              hpen
);

  logic [FLASH_BITS-1:0] flash_cnt;
  logic                  cfg_we_d;
  logic                  cfg_wr;
  logic                  fetch_slot;
  logic                  wide_vblank;

  // ---------------------------------------------------------------------------
  // Raster counters, advanced on the positive pixel phase
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      flash_cnt <= '0;
    end else if (ce_6mp) begin
      if (hc == H_TOTAL - 9'd1) begin
        hc <= '0;
        if (vc == V_TOTAL - 9'd1) begin
          vc        <= '0;
          flash_cnt <= flash_cnt + FLASH_BITS'(1);
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end
    end
  end

  assign flash = flash_cnt[FLASH_BITS-1];

  // ---------------------------------------------------------------------------
  // Timing outputs, fetch qualifier and frame interrupt on the negative phase.
  // Both phases read the same pre-edge hc/vc when ce_6mp and ce_6mn coincide.
  // ---------------------------------------------------------------------------
  assign fetch_slot  = (hc >= H_ACT_START) && (vc < V_ACT) && (hc[2:0] == 3'd0);
  assign wide_vblank = !((vc < V_ACT + 9'd1) || (vc >= V_TOTAL - 9'd5));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      HBlank    <= 1'b0;
      HSync     <= 1'b0;
      VBlank    <= 1'b0;
      VSync     <= 1'b0;
      fetch     <= 1'b0;
      fetch_stb <= 1'b0;
      INT_frame <= 1'b0;
    end else begin
      fetch_stb <= 1'b0;
      if (ce_6mn) begin
        if (hc == HB_START)    HBlank <= 1'b1;
        else if (hc == HB_END) HBlank <= 1'b0;

        if (hc == HS_START)    HSync <= 1'b1;
        else if (hc == HS_END) HSync <= 1'b0;

        if (vc == VS_START)    VSync <= 1'b1;
        else if (vc == VS_END) VSync <= 1'b0;

        // Vertical blank moves only at the end of horizontal blank.
        if (hc == HB_END) begin
          if (wide)                VBlank <= wide_vblank;
          else if (vc == VB_START) VBlank <= 1'b1;
          else if (vc == VB_END)   VBlank <= 1'b0;
        end

        if (hc == '0) fetch <= 1'b0;
        if (fetch_slot) begin
          fetch     <= ~soff;
          fetch_stb <= ~soff;
        end

        INT_frame <= (vc == VS_END) && (hc < INT_LEN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line-interrupt channels; writes act on the rising edge of cfg_we
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) cfg_we_d <= 1'b0;
    else       cfg_we_d <= cfg_we;
  end

  assign cfg_wr = cfg_we && !cfg_we_d;

  for (genvar i = 0; i < NUM_LINE_INT; i++) begin : g_line
    raster_line_cmp #(
      .V_ACT   (V_ACT),
      .INT_LEN (INT_LEN)
    ) u_cmp (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .wr_en    (cfg_wr && (cfg_sel == 3'(i))),
      .din      (cfg_din),
      .ce_6mn   (ce_6mn),
      .hc       (hc),
      .vc       (vc),
      .int_line (INT_line[i])
    );
  end

  // ---------------------------------------------------------------------------
  // CPU contention qualifiers
  // ---------------------------------------------------------------------------
  assign io_contention  = !is_cpu_slot(hc[2:0]);
  assign mem_contention = (fetch || (mode == 2'd0 && !full_zx && hc[6]))
                        ? !is_cpu_slot(hc[2:0])
                        : (hc[1:0] != 2'd1);

  // ---------------------------------------------------------------------------
  // Light-pen position latches
  // ---------------------------------------------------------------------------
`ifdef RASTER_LIGHTPEN_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lpen <= 8'd0;
      hpen <= 8'd0;
    end else if (ce_6mn && !io_contention) begin
      // Bits 2:0 stay clear; the port block merges its own status into them.
      lpen <= {{5{fetch}} & {~hc[7], hc[6:3]}, 3'b000};
      hpen <= (soff || vc > V_ACT) ? V_ACT[7:0] : vc[7:0];
    end
  end
`else
  assign lpen = 8'd0;
  assign hpen = 8'd192;
`endif

endmodule
